// File: rtl/alu_arbiter.sv
//==============================================================================
// alu_arbiter : shares one combinational ALU between two requesters and
//               returns each result through a registered per-port response slot
// Revision    : 1.0
//==============================================================================
`default_nettype none

module alu_arbiter #(
    parameter int WIDTH     = 32,
    parameter int PRIO_MODE = 0,
    parameter int MAX_WAIT  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0Valid,
    output logic             req0Ready,
    input  logic [3:0]       req0Ctl,
    input  logic [WIDTH-1:0] req0A,
    input  logic [WIDTH-1:0] req0B,
    input  logic             req1Valid,
    output logic             req1Ready,
    input  logic [3:0]       req1Ctl,
    input  logic [WIDTH-1:0] req1A,
    input  logic [WIDTH-1:0] req1B,
    output logic [3:0]       aluCtl,
    output logic [WIDTH-1:0] aluA,
    output logic [WIDTH-1:0] aluB,
    input  logic [WIDTH-1:0] aluResult,
    output logic             rsp0Valid,
    input  logic             rsp0Ready,
    output logic [WIDTH-1:0] rsp0Data,
    output logic             rsp1Valid,
    input  logic             rsp1Ready,
    output logic [WIDTH-1:0] rsp1Data
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic       elig0;
    logic       elig1;
    logic       win1;
    logic       grant0;
    logic       grant1;
    logic       last_grant;
    logic [3:0] wait_cnt;

    // rst_n gates eligibility so nothing is accepted or driven while in reset
    always_comb begin
        elig0 = rst_n & req0Valid & (~rsp0Valid | rsp0Ready);
        elig1 = rst_n & req1Valid & (~rsp1Valid | rsp1Ready);
    end

    generate
        if (PRIO_MODE == 1) begin : g_fixed_prio
            assign win1 = (wait_cnt == WAIT_LIMIT);
        end else begin : g_round_robin
            assign win1 = ~last_grant;
        end
    endgenerate

    always_comb begin
        grant0 = elig0 & ~(elig1 & win1);
        grant1 = elig1 & ~grant0;
    end

    assign req0Ready = grant0;
    assign req1Ready = grant1;

    always_comb begin
        aluCtl = 4'b0000;
        aluA   = '0;
        aluB   = '0;
        if (grant0) begin
            aluCtl = req0Ctl;
            aluA   = req0A;
            aluB   = req0B;
        end else if (grant1) begin
            aluCtl = req1Ctl;
            aluA   = req1A;
            aluB   = req1B;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            wait_cnt   <= 4'd0;
        end else begin
            if (grant0 | grant1) begin
                last_grant <= grant1;
            end
            if (!elig1 || grant1) begin
                wait_cnt <= 4'd0;
            end else if (elig0 && wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    // a slot being drained this cycle may be refilled by a new grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0Valid <= 1'b0;
            rsp0Data  <= '0;
            rsp1Valid <= 1'b0;
            rsp1Data  <= '0;
        end else begin
            if (grant0) begin
                rsp0Valid <= 1'b1;
                rsp0Data  <= aluResult;
            end else if (rsp0Ready) begin
                rsp0Valid <= 1'b0;
            end
            if (grant1) begin
                rsp1Valid <= 1'b1;
                rsp1Data  <= aluResult;
            end else if (rsp1Ready) begin
                rsp1Valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between two requesters: port 0 is the execute stage and port 1 is the address/branch helper. Each request carries an ALU control code from the ALU decode (4-bit `aluCtl` encoding from `defines.vh`) plus two operands. The block arbitrates per cycle, drives the shared ALU, registers the result into a per-port response slot, and returns it over a valid/ready handshake. It sits between the decode/issue logic and the ALU instance.

## Interface
- `WIDTH`, 32, operand/result width.
- `PRIO_MODE`, 0, arbitration policy: 0 = round-robin, 1 = fixed priority (port 0 wins) with starvation guard.
- `MAX_WAIT`, 4, starvation guard threshold in fixed mode: consecutive lost contended cycles for port 1. Legal range 1..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `req0Valid` / `req1Valid`  in  1  request present.
- `req0Ready` / `req1Ready`  out  1  request accepted this cycle (the grant).
- `req0Ctl` / `req1Ctl`  in  4  ALU control code.
- `req0A`, `req0B` / `req1A`, `req1B`  in  WIDTH  operands.
- `aluCtl`  out  4  to the shared ALU.
- `aluA`, `aluB`  out  WIDTH  to the shared ALU.
- `aluResult`  in  WIDTH  from the shared ALU, combinational in the same cycle.
- `rsp0Valid` / `rsp1Valid`  out  1  response slot full.
- `rsp0Ready` / `rsp1Ready`  in  1  response consumed.
- `rsp0Data` / `rsp1Data`  out  WIDTH  registered result.

## Operation
- **Eligibility.** Port N is eligible when `reqNValid` is high and either `rspNValid` is 0 or `rspNReady` is 1. Each port allows at most one outstanding response. A slot being drained in the same cycle may be refilled.
- **Grant.** At most one grant per cycle; `reqNReady` equals grantN and is combinational.
  - Only one port eligible: it is granted.
  - No port eligible: no grant; `aluCtl`=4'b0000, `aluA`=`aluB`=0.
- **Contention with `PRIO_MODE`=0.** Grant the port that is not `lastGrant`. `lastGrant` updates only on a grant and resets to 1, so port 0 wins the first contention.
- **Contention with `PRIO_MODE`=1.** Port 0 wins unless `waitCnt` equals `MAX_WAIT`, in which case port 1 wins.
  - `waitCnt` (4 bits, reset 0) increments on each contended cycle that port 1 loses.
  - `waitCnt` clears whenever port 1 is granted, or port 1 is not eligible.
  - `waitCnt` saturates at `MAX_WAIT`.
- **ALU drive.** While granted, `aluCtl`/`aluA`/`aluB` are muxed from the granted port.
- **Response slot.** On grant, `rspNData` is loaded with `aluResult` and `rspNValid` is set.
  - If `rspNValid` is 1 and `rspNReady` is 1 with no new grant to port N, `rspNValid` clears and `rspNData` holds its value.
  - `rspNData` is stable while `rspNValid` is 1 and `rspNReady` is 0.
- **Requester rules.** `reqNValid` must not depend on `reqNReady`. Request fields must be held until accepted.

## Timing
- **Reset values.** All outputs are 0 during and after reset: `rsp*Valid`, `rsp*Data`, `req*Ready`, and the ALU drive outputs. Internal state resets to `lastGrant`=1, `waitCnt`=0.
- **Reset mid-operation.** Pending responses are discarded immediately (asynchronous). Requests are not accepted while `rst_n` is 0.
- **Latency.** A request accepted in cycle N has `rspValid` high in cycle N+1.
- **Throughput.** One accepted request per cycle in aggregate. A single port sustains one per cycle if it drains its response every cycle.
- **Wrap/saturation.** `waitCnt` never exceeds `MAX_WAIT`. `lastGrant` simply toggles.

## Test plan
- **Reset.** Assert `rst_n`=0 with both `reqValid` high -> `req0Ready`=`req1Ready`=0, `rsp0Valid`=`rsp1Valid`=0, `aluCtl`=0. Release reset -> port 0 is granted first.
- **Single request.** Port 0 sends ADD with A=5, B=7 in cycle 0 (model ALU) -> `req0Ready`=1 and `aluA`=5 in cycle 0. In cycle 1, `rsp0Valid`=1 and `rsp0Data`=12.
- **Round-robin.** `PRIO_MODE`=0, both ports valid and always draining for 6 cycles -> grants go 0,1,0,1,0,1.
- **Backpressure.** Hold `rsp1Ready`=0 with port 1 valid -> one grant, then `req1Ready`=0 and `rsp1Data` stable. Port 0 receives every grant. After `rsp1Ready`=1 for one cycle, port 1 is regranted the same cycle.
- **Starvation guard.** `PRIO_MODE`=1, `MAX_WAIT`=3, both ports continuously valid -> grants go 0,0,0,1 and repeat.
- **Reset mid-operation.** Pulse `rst_n` low while `rsp0Valid`=1 -> `rsp0Valid` drops asynchronously. After release, `lastGrant` has returned to 1 and `waitCnt` to 0.
